// File: rtl/seg7_scan_ctrl.sv
// Shared-decoder 7-seg scan: per-slot blank gap, frame-atomic load with one-cycle ack.
// Latency: pins are combinational decodes of registered state; no backpressure, load always accepted.
module seg7_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  output logic                  load_ack,
  output logic [3:0]            dec_in,
  output logic                  dec_enable,
  output logic [N_DIGITS-1:0]   an_out,
  output logic                  dp_out
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(N_DIGITS - 1);

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DW-1:0]         digit;
  logic [4*N_DIGITS-1:0] disp_val;
  logic [N_DIGITS-1:0]   disp_dp;
  logic [4*N_DIGITS-1:0] pend_val;
  logic [N_DIGITS-1:0]   pend_dp;
  logic                  pend_valid;

  logic slot_end;
  logic frame_end;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (digit == DIG_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BLANK;
      cnt        <= '0;
      digit      <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) begin
        digit <= (digit == DIG_LAST) ? '0 : digit + 1'b1;
      end

      case (state)
        BLANK:   if (cnt == BLANK_LAST) state <= DRIVE;
        DRIVE:   if (slot_end) state <= BLANK;
        default: state <= BLANK;
      endcase

      load_ack <= 1'b0;
      if (frame_end && pend_valid) begin
        disp_val   <= pend_val;
        disp_dp    <= pend_dp;
        pend_valid <= 1'b0;
        load_ack   <= 1'b1;
      end
      // A load on the boundary edge queues behind the data being applied now.
      if (load) begin
        pend_val   <= value;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end
    end
  end

  logic [DW+1:0] nib_base;
  logic          show;

  always_comb begin
    nib_base   = {digit, 2'b00};
    show       = (state == DRIVE) && digit_en[digit];
    dec_in     = disp_val[nib_base +: 4];
    an_out     = '1;
    dp_out     = 1'b1;
    dec_enable = 1'b0;
    if (show) begin
      an_out[digit] = 1'b0;
      dp_out        = ~disp_dp[digit];
      dec_enable    = 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = 4'hF;
  logic        load_ack;
  logic [3:0]  dec_in;
  logic        dec_enable;
  logic [3:0]  an_out;
  logic        dp_out;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  seg7_scan_ctrl #(.N_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .load_ack(load_ack), .dec_in(dec_in),
    .dec_enable(dec_enable), .an_out(an_out), .dp_out(dp_out)
  );

  always #5 clk = ~clk;

  // Expected {an_out, dp_out, dec_enable, dec_in} for cycle c of a frame-aligned run.
  function automatic logic [9:0] exp_pins(int c, logic [15:0] v, logic [3:0] d, logic [3:0] en);
    int s;
    int p;
    logic [3:0] an;
    logic dpo;
    logic e;
    logic [3:0] nib;
    s   = (c / 8) % 4;
    p   = c % 8;
    an  = 4'hF;
    dpo = 1'b1;
    e   = 1'b0;
    nib = v[s*4 +: 4];
    if (p >= 2 && en[s]) begin
      an[s] = 1'b0;
      dpo   = ~d[s];
      e     = 1'b1;
    end
    return {an, dpo, e, nib};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({an_out, dp_out, dec_enable, dec_in, load_ack} !== {4'b1111, 1'b1, 1'b0, 4'h0, 1'b0})
      $display("FAIL reset_state got an=%b dp=%b en=%b dec=%h ack=%b", an_out, dp_out, dec_enable, dec_in, load_ack);
    else n_pass++;
  endtask

  task automatic test_idle();
    logic [9:0] exp;
    do_reset();
    while (cyc < 32) begin
      exp = exp_pins(cyc, 16'h0, 4'h0, 4'hF);
      n_total++;
      if ({an_out, dp_out, dec_enable, dec_in} !== exp)
        $display("FAIL idle c=%0d got %b required %b", cyc, {an_out, dp_out, dec_enable, dec_in}, exp);
      else n_pass++;
      n_total++;
      if (load_ack !== 1'b0) $display("FAIL idle_ack c=%0d got %b required 0", cyc, load_ack);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_load();
    logic [9:0] exp;
    do_reset();
    while (cyc < 64) begin
      load  = (cyc == 3);
      value = 16'h4321;
      dp_in = 4'b0100;
      exp = (cyc < 32) ? exp_pins(cyc, 16'h0, 4'h0, 4'hF) : exp_pins(cyc, 16'h4321, 4'b0100, 4'hF);
      n_total++;
      if ({an_out, dp_out, dec_enable, dec_in} !== exp)
        $display("FAIL load c=%0d got %b required %b", cyc, {an_out, dp_out, dec_enable, dec_in}, exp);
      else n_pass++;
      n_total++;
      if (load_ack !== (cyc == 32)) $display("FAIL load_ack c=%0d got %b required %b", cyc, load_ack, cyc == 32);
      else n_pass++;
      if (cyc == 36) begin
        n_total++;
        if ({dec_in, an_out, dp_out} !== {4'h1, 4'b1110, 1'b1})
          $display("FAIL load_d0 got dec=%h an=%b dp=%b required 1 1110 1", dec_in, an_out, dp_out);
        else n_pass++;
      end
      if (cyc == 52) begin
        n_total++;
        if ({dec_in, an_out, dp_out} !== {4'h3, 4'b1011, 1'b0})
          $display("FAIL load_d2 got dec=%h an=%b dp=%b required 3 1011 0", dec_in, an_out, dp_out);
        else n_pass++;
      end
      step();
    end
    load = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp;
    int acks;
    acks = 0;
    do_reset();
    while (cyc < 72) begin
      load  = (cyc == 2) || (cyc == 5);
      value = (cyc == 2) ? 16'hAAAA : 16'hBBBB;
      dp_in = (cyc == 2) ? 4'h0 : 4'hF;
      if (load_ack === 1'b1) acks++;
      exp = (cyc < 32) ? exp_pins(cyc, 16'h0, 4'h0, 4'hF) : exp_pins(cyc, 16'hBBBB, 4'hF, 4'hF);
      n_total++;
      if ({an_out, dp_out, dec_enable, dec_in} !== exp)
        $display("FAIL b2b c=%0d got %b required %b", cyc, {an_out, dp_out, dec_enable, dec_in}, exp);
      else n_pass++;
      step();
    end
    load = 1'b0;
    n_total++;
    if (acks != 1) $display("FAIL b2b_acks got %0d required 1", acks);
    else n_pass++;
  endtask

  task automatic test_boundary_load();
    logic [9:0] exp;
    logic exp_ack;
    do_reset();
    while (cyc < 96) begin
      load  = (cyc == 5) || (cyc == 31);
      value = (cyc == 5) ? 16'hAAAA : 16'h5555;
      dp_in = (cyc == 5) ? 4'b0001 : 4'b0000;
      if (cyc < 32)      exp = exp_pins(cyc, 16'h0, 4'h0, 4'hF);
      else if (cyc < 64) exp = exp_pins(cyc, 16'hAAAA, 4'b0001, 4'hF);
      else               exp = exp_pins(cyc, 16'h5555, 4'b0000, 4'hF);
      exp_ack = (cyc == 32) || (cyc == 64);
      n_total++;
      if ({an_out, dp_out, dec_enable, dec_in} !== exp)
        $display("FAIL boundary c=%0d got %b required %b", cyc, {an_out, dp_out, dec_enable, dec_in}, exp);
      else n_pass++;
      n_total++;
      if (load_ack !== exp_ack) $display("FAIL boundary_ack c=%0d got %b required %b", cyc, load_ack, exp_ack);
      else n_pass++;
      step();
    end
    load = 1'b0;
  endtask

  task automatic test_digit_en();
    logic [9:0] exp;
    do_reset();
    while (cyc < 64) begin
      load     = (cyc == 0);
      value    = 16'h4321;
      dp_in    = 4'b0100;
      digit_en = (cyc >= 32) ? 4'b1011 : 4'hF;
      exp = (cyc < 32) ? exp_pins(cyc, 16'h0, 4'h0, 4'hF) : exp_pins(cyc, 16'h4321, 4'b0100, 4'b1011);
      n_total++;
      if ({an_out, dp_out, dec_enable, dec_in} !== exp)
        $display("FAIL digit_en c=%0d got %b required %b", cyc, {an_out, dp_out, dec_enable, dec_in}, exp);
      else n_pass++;
      if (cyc == 52) begin
        n_total++;
        if ({an_out, dec_enable, dp_out, dec_in} !== {4'b1111, 1'b0, 1'b1, 4'h3})
          $display("FAIL digit_en_d2 got an=%b en=%b dp=%b dec=%h required 1111 0 1 3", an_out, dec_enable, dp_out, dec_in);
        else n_pass++;
      end
      step();
    end
    load     = 1'b0;
    digit_en = 4'hF;
  endtask

  task automatic test_reset_mid();
    logic [9:0] exp;
    do_reset();
    while (cyc < 50) begin
      load  = (cyc == 3);
      value = 16'h4321;
      dp_in = 4'b0100;
      step();
    end
    load = 1'b0;
    n_total++;
    if (an_out !== 4'b1011) $display("FAIL mid_pre an got %b required 1011", an_out);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    n_total++;
    if ({an_out, dp_out, dec_enable, dec_in, load_ack} !== {4'b1111, 1'b1, 1'b0, 4'h0, 1'b0})
      $display("FAIL mid_reset got an=%b dp=%b en=%b dec=%h ack=%b", an_out, dp_out, dec_enable, dec_in, load_ack);
    else n_pass++;
    while (cyc < 72) begin
      exp = exp_pins(cyc, 16'h0, 4'h0, 4'hF);
      n_total++;
      if ({an_out, dp_out, dec_enable, dec_in} !== exp)
        $display("FAIL mid_after c=%0d got %b required %b", cyc, {an_out, dp_out, dec_enable, dec_in}, exp);
      else n_pass++;
      n_total++;
      if (load_ack !== 1'b0) $display("FAIL mid_ack c=%0d got %b required 0", cyc, load_ack);
      else n_pass++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load();
    test_back_to_back();
    test_boundary_load();
    test_digit_en();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
